// File: rtl/bicubic_coeff_mul_pkg.sv
// Shared constants for the bicubic scaler's per-tap arithmetic.
// DS_LAT must track the pipeline depth of mul_add_2.
package bicubic_coeff_mul_pkg;

    localparam int PIX_W  = 8;
    localparam int PH_W   = 8;
    localparam int A_W    = 40;
    localparam int B_W    = 38;
    localparam int C_W    = 28;
    localparam int D_W    = 18;
    localparam int DS_LAT = 3;

endpackage

// File: rtl/valid_dly.sv
// N-deep valid delay line with synchronous active-low clear.
module valid_dly
    import bicubic_coeff_mul_pkg::*;
#(
    parameter int N = DS_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | N'(d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[N-1];

endmodule

// File: rtl/bicubic_coeff_mul.sv
// Catmull-Rom coefficient and partial-product pipeline feeding mul_add_2.
// Outputs are wrapped two's-complement; the recombiner only uses bits mod 2^33.
module bicubic_coeff_mul #(
    parameter int PIX_W  = bicubic_coeff_mul_pkg::PIX_W,
    parameter int PH_W   = bicubic_coeff_mul_pkg::PH_W,
    parameter int DS_LAT = bicubic_coeff_mul_pkg::DS_LAT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [PIX_W-1:0]                   p0,
    input  logic [PIX_W-1:0]                   p1,
    input  logic [PIX_W-1:0]                   p2,
    input  logic [PIX_W-1:0]                   p3,
    input  logic [PH_W-1:0]                    phase,
    output logic [bicubic_coeff_mul_pkg::A_W-1:0] a,
    output logic [bicubic_coeff_mul_pkg::B_W-1:0] b,
    output logic [bicubic_coeff_mul_pkg::C_W-1:0] c,
    output logic [bicubic_coeff_mul_pkg::D_W-1:0] d,
    output logic                               out_valid,
    output logic                               res_valid
);
    import bicubic_coeff_mul_pkg::*;

    localparam int K3_W = PIX_W + 3;
    localparam int K2_W = PIX_W + 4;
    localparam int K1_W = PIX_W + 1;
    localparam int K0_W = PIX_W + 2;
    localparam int U2_W = 2 * PH_W;
    localparam int U3_W = 3 * PH_W;

    logic [K2_W-1:0] e0, e1, e2, e3, k3_full;

    logic [K3_W-1:0] s1_k3_q,  s1_k3_d;
    logic [K2_W-1:0] s1_k2_q,  s1_k2_d;
    logic [K1_W-1:0] s1_k1_q,  s1_k1_d;
    logic [K0_W-1:0] s1_nk0_q, s1_nk0_d;
    logic [PH_W-1:0] s1_u_q,   s1_u_d;
    logic [U2_W-1:0] s1_u2_q,  s1_u2_d;
    logic            s1_vld_q, s1_vld_d;

    logic [U3_W-1:0] s2_u3_q,  s2_u3_d;
    logic [B_W-1:0]  s2_b_q,   s2_b_d;
    logic [C_W-1:0]  s2_c_q,   s2_c_d;
    logic [K3_W-1:0] s2_k3_q,  s2_k3_d;
    logic [K0_W-1:0] s2_nk0_q, s2_nk0_d;
    logic            s2_vld_q, s2_vld_d;

    logic [A_W-1:0]  a_q, a_d;
    logic [B_W-1:0]  b_q, b_d;
    logic [C_W-1:0]  c_q, c_d;
    logic [D_W-1:0]  d_q, d_d;
    logic            out_vld_q, out_vld_d;

    always_comb begin
        // Coefficients in K2_W bits; every K fits, so truncation is exact.
        e0       = {4'b0, p0};
        e1       = {4'b0, p1};
        e2       = {4'b0, p2};
        e3       = {4'b0, p3};
        k3_full  = e3 - e0 + (e1 << 1) + e1 - (e2 << 1) - e2;
        s1_k3_d  = k3_full[K3_W-1:0];
        s1_k2_d  = (e0 << 1) - (e1 << 2) - e1 + (e2 << 2) - e3;
        s1_k1_d  = {1'b0, p2} - {1'b0, p0};
        s1_nk0_d = '0 - {1'b0, p1, 1'b0};
        s1_u_d   = phase;
        s1_u2_d  = U2_W'(phase) * U2_W'(phase);
        s1_vld_d = in_valid;

        // Signed x unsigned products: sign-extend the coefficient, zero-extend the power.
        s2_u3_d  = U3_W'(s1_u2_q) * U3_W'(s1_u_q);
        s2_b_d   = '0 - ({{(B_W-K2_W){s1_k2_q[K2_W-1]}}, s1_k2_q} * B_W'(s1_u2_q));
        s2_c_d   = {{(C_W-K1_W){s1_k1_q[K1_W-1]}}, s1_k1_q} * C_W'(s1_u_q);
        s2_k3_d  = s1_k3_q;
        s2_nk0_d = s1_nk0_q;
        s2_vld_d = s1_vld_q;

        a_d       = {{(A_W-K3_W){s2_k3_q[K3_W-1]}}, s2_k3_q} * A_W'(s2_u3_q);
        b_d       = s2_b_q;
        c_d       = s2_c_q;
        d_d       = {{(D_W-K0_W){s2_nk0_q[K0_W-1]}}, s2_nk0_q};
        out_vld_d = s2_vld_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_k3_q   <= '0;
            s1_k2_q   <= '0;
            s1_k1_q   <= '0;
            s1_nk0_q  <= '0;
            s1_u_q    <= '0;
            s1_u2_q   <= '0;
            s1_vld_q  <= 1'b0;
            s2_u3_q   <= '0;
            s2_b_q    <= '0;
            s2_c_q    <= '0;
            s2_k3_q   <= '0;
            s2_nk0_q  <= '0;
            s2_vld_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            out_vld_q <= 1'b0;
        end else begin
            s1_k3_q   <= s1_k3_d;
            s1_k2_q   <= s1_k2_d;
            s1_k1_q   <= s1_k1_d;
            s1_nk0_q  <= s1_nk0_d;
            s1_u_q    <= s1_u_d;
            s1_u2_q   <= s1_u2_d;
            s1_vld_q  <= s1_vld_d;
            s2_u3_q   <= s2_u3_d;
            s2_b_q    <= s2_b_d;
            s2_c_q    <= s2_c_d;
            s2_k3_q   <= s2_k3_d;
            s2_nk0_q  <= s2_nk0_d;
            s2_vld_q  <= s2_vld_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign out_valid = out_vld_q;

    valid_dly #(.N(DS_LAT)) u_res_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out_vld_q),
        .q     (res_valid)
    );

endmodule
